// File: rtl/rv32i_instr_encoder.sv
`default_nettype none
// ============================================================================
// rv32i_instr_encoder: packs decoded RV32I fields into 32-bit words and
// streams them into instruction memory from a programmable base address.
// Revision: 1.0
// ============================================================================
module rv32i_instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [12:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_count
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   rem_in;
  logic [ADDR_W:0]   rem_out;
  logic [ADDR_W-1:0] wr_addr;
  logic              out_full;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        errs;

  logic              accept;
  logic              write_done;
  logic              illegal;
  logic [31:0]       enc_word;

  always_comb begin
    enc_word = NOP_WORD;
    illegal  = 1'b0;
    case (in_kind)
      3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd1: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
        illegal  = in_imm[12] ^ in_imm[11];
      end
      3'd2: begin
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
        illegal  = in_imm[12] ^ in_imm[11];
      end
      3'd3: begin
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], 7'b1100011};
        illegal  = in_imm[0];
      end
      3'd4: begin
        // Shift-immediates carry funct7 in the upper immediate bits
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        illegal = in_imm[12] ^ in_imm[11];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign write_done = out_full && imem_ready;
  assign in_ready   = (state == LOAD) && (rem_in != '0) && (!out_full || write_done);
  assign accept     = in_valid && in_ready;

  assign imem_we    = out_full;
  assign imem_addr  = out_addr;
  assign imem_wdata = out_word;
  assign busy       = (state == LOAD);
  assign done       = (state == DONE);
  assign err_count  = errs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rem_in   <= '0;
      rem_out  <= '0;
      wr_addr  <= '0;
      out_full <= 1'b0;
      out_word <= '0;
      out_addr <= '0;
      errs     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            wr_addr  <= base_addr;
            rem_in   <= prog_len;
            rem_out  <= prog_len;
            errs     <= '0;
            out_full <= 1'b0;
            state    <= (prog_len == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          // Accepting a bundle while the previous word drains keeps the register full
          if (accept) begin
            out_full <= 1'b1;
            out_word <= illegal ? NOP_WORD : enc_word;
            out_addr <= wr_addr;
            wr_addr  <= wr_addr + 1'b1;
            rem_in   <= rem_in - 1'b1;
            if (illegal && errs != 8'hFF)
              errs <= errs + 8'd1;
          end else if (write_done) begin
            out_full <= 1'b0;
          end
          if (write_done) begin
            rem_out <= rem_out - 1'b1;
            if (rem_out == (ADDR_W+1)'(1))
              state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_instr_encoder.sv
`default_nettype none
// Directed-vector bench for rv32i_instr_encoder with a write monitor.
module tb_rv32i_instr_encoder;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   prog_len;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [12:0]       in_imm;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy, done;
  logic [7:0]        err_count;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];

  rv32i_instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .prog_len(prog_len), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge, so the falling edge sees the handshake that commits next
  always @(negedge clk) begin
    if (imem_we && imem_ready) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_session(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n);
    wa.delete();
    wd.delete();
    base_addr = b;
    prog_len  = n;
    start     = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [12:0] imm);
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] imm);
    int n;
    set_fields(k, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL wait_done: done=%b required 1 within 50 cycles", done);
    end
  endtask

  task automatic check_writes(input string name, input int cnt,
                              input logic [ADDR_W-1:0] a0, input logic [31:0] d0,
                              input logic [ADDR_W-1:0] a1, input logic [31:0] d1,
                              input logic [ADDR_W-1:0] a2, input logic [31:0] d2);
    logic [ADDR_W-1:0] ea[3];
    logic [31:0]       ed[3];
    ea[0] = a0; ea[1] = a1; ea[2] = a2;
    ed[0] = d0; ed[1] = d1; ed[2] = d2;
    total++;
    if (wa.size() != cnt) begin
      bad++;
      $display("FAIL %s_count: writes=%0d required %0d", name, wa.size(), cnt);
    end else begin
      for (int i = 0; i < cnt; i++) begin
        total++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          bad++;
          $display("FAIL %s_write%0d: addr=%h data=%h required addr=%h data=%h",
                   name, i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({in_ready, imem_we, busy, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: rdy/we/busy/done=%b required 0000",
               {in_ready, imem_we, busy, done});
    end
    total++;
    if (imem_addr !== '0 || imem_wdata !== 32'h0 || err_count !== 8'h0) begin
      bad++;
      $display("FAIL reset_values: addr=%h data=%h err=%h required 0 0 0",
               imem_addr, imem_wdata, err_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_r_single;
    begin_session(8'h10, 9'd1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL r_busy: busy=%b required 1", busy);
    end
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0);
    total++;
    if (imem_we !== 1'b1 || imem_addr !== 8'h10 || imem_wdata !== 32'h002081B3) begin
      bad++;
      $display("FAIL r_latency: we=%b addr=%h data=%h required 1 10 002081b3",
               imem_we, imem_addr, imem_wdata);
    end
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || imem_we !== 1'b0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL r_done: done=%b busy=%b we=%b err=%0d required 1 0 0 0",
               done, busy, imem_we, err_count);
    end
    check_writes("r_single", 1, 8'h10, 32'h002081B3, '0, '0, '0, '0);
  endtask

  task automatic test_back_to_back;
    begin_session(8'h20, 9'd3);
    send(3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'h1FFC);
    send(3'd2, 5'd0, 5'd1, 5'd6, 3'd2, 7'd0, 13'h0008);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8);
    wait_done();
    check_writes("lsb", 3, 8'h20, 32'hFFC12283, 8'h21, 32'h0060A423, 8'h22, 32'hFE208CE3);
    total++;
    if (err_count !== 8'd0) begin
      bad++;
      $display("FAIL lsb_err: err_count=%0d required 0", err_count);
    end
  endtask

  task automatic test_wrap_backpressure;
    logic [31:0] held;
    begin_session(8'hFF, 9'd3);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'd5);
    set_fields(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 13'h0);
    in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL wrap_refill: in_ready=%b required 1", in_ready);
    end
    tick();
    imem_ready = 1'b0;
    set_fields(3'd4, 5'd4, 5'd4, 5'd0, 3'd1, 7'd0, 13'd3);
    #1;
    held = imem_wdata;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (in_ready !== 1'b0 || imem_we !== 1'b1 || imem_addr !== 8'h00 ||
          imem_wdata !== 32'h403100B3) begin
        bad++;
        $display("FAIL wrap_stall%0d: rdy=%b we=%b addr=%h data=%h required 0 1 00 403100b3",
                 i, in_ready, imem_we, imem_addr, imem_wdata);
      end
      tick();
    end
    total++;
    if (imem_wdata !== held) begin
      bad++;
      $display("FAIL wrap_hold: data=%h required %h", imem_wdata, held);
    end
    imem_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL wrap_release: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    wait_done();
    check_writes("wrap", 3, 8'hFF, 32'h00500093, 8'h00, 32'h403100B3, 8'h01, 32'h00321213);
  endtask

  task automatic test_illegal;
    begin_session(8'h40, 9'd2);
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'h0);
    send(3'd4, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 13'h0800);
    wait_done();
    check_writes("illegal", 2, 8'h40, 32'h00000013, 8'h41, 32'h00000013, '0, '0);
    total++;
    if (err_count !== 8'd2) begin
      bad++;
      $display("FAIL illegal_err: err_count=%0d required 2", err_count);
    end
    // Misaligned branch offset and an out-of-range load immediate
    begin_session(8'h50, 9'd3);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0003);
    send(3'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 13'h1000);
    send(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'h1FFF);
    wait_done();
    check_writes("illegal2", 3, 8'h50, 32'h00000013, 8'h51, 32'h00000013, 8'h52, 32'hFFF00113);
    total++;
    if (err_count !== 8'd2) begin
      bad++;
      $display("FAIL illegal2_err: err_count=%0d required 2", err_count);
    end
  endtask

  task automatic test_saturate;
    begin_session(8'h00, 9'd256);
    for (int i = 0; i < 256; i++)
      send(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0);
    wait_done();
    total++;
    if (err_count !== 8'd255 || wa.size() != 256) begin
      bad++;
      $display("FAIL saturate: err_count=%0d writes=%0d required 255 256", err_count, wa.size());
    end
  endtask

  task automatic test_idle_ignore;
    set_fields(3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'h0);
    wa.delete();
    in_valid = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready: in_ready=%b required 0", in_ready);
    end
    tick();
    tick();
    in_valid = 1'b0;
    total++;
    if (wa.size() != 0 || done !== 1'b1) begin
      bad++;
      $display("FAIL idle_ignore: writes=%0d done=%b required 0 1", wa.size(), done);
    end
  endtask

  task automatic test_reset_mid;
    begin_session(8'h80, 9'd4);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0);
    total++;
    if (wa.size() != 1) begin
      bad++;
      $display("FAIL mid_prewrites: writes=%0d required 1", wa.size());
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || imem_we !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b we=%b done=%b rdy=%b required 0 0 0 0",
               busy, imem_we, done, in_ready);
    end
    begin_session(8'h90, 9'd0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_len: done=%b busy=%b required 1 0", done, busy);
    end
    tick();
    tick();
    total++;
    if (wa.size() != 0) begin
      bad++;
      $display("FAIL zero_len_writes: writes=%0d required 0", wa.size());
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; prog_len = '0;
    in_valid = 1'b0; imem_ready = 1'b1;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0);
    test_reset();
    test_r_single();
    test_back_to_back();
    test_wrap_backpressure();
    test_illegal();
    test_saturate();
    test_idle_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
